tjmono_rx_arbiter: RTL and testbench

TJMONO_RX_ARBITER -- requirements
Module: tjmono_rx_arbiter

---
 rtl/tjmono_rx_arbiter_if.sv | 27 ++
 rtl/tjmono_rx_arbiter.sv | 143 ++++++++++++++
 tb/tb_tjmono_rx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tjmono_rx_arbiter_if.sv
// rtl/tjmono_rx_arbiter_if.sv - source FIFO / downstream / status bundle for the tjmono RX arbiter
interface tjmono_rx_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]    SRC_EMPTY;
  logic [32*N_SRC-1:0] SRC_DATA;
  logic [N_SRC-1:0]    SRC_READ;
  logic [N_SRC-1:0]    SRC_ENABLE;
  logic                OUT_FULL;
  logic                OUT_WRITE;
  logic [31:0]         OUT_DATA;
  logic [N_SRC-1:0]    GRANT;
  logic                TIMEOUT_ERR;
  logic                ERR_CLR;
  logic [7:0]          TIMEOUT_CNT;
  logic [31:0]         WORD_CNT;

  modport master (
    input  SRC_EMPTY, SRC_DATA, SRC_ENABLE, OUT_FULL, ERR_CLR,
    output SRC_READ, OUT_WRITE, OUT_DATA, GRANT, TIMEOUT_ERR, TIMEOUT_CNT, WORD_CNT
  );

  modport slave (
    output SRC_EMPTY, SRC_DATA, SRC_ENABLE, OUT_FULL, ERR_CLR,
    input  SRC_READ, OUT_WRITE, OUT_DATA, GRANT, TIMEOUT_ERR, TIMEOUT_CNT, WORD_CNT
  );
endinterface

// File: rtl/tjmono_rx_arbiter.sv
// rtl/tjmono_rx_arbiter.sv - round-robin record arbiter merging tjmono RX source FIFOs into one stream
module tjmono_rx_arbiter #(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 16
) (
  input logic                    BUS_CLK,
  input logic                    BUS_RST_N,
  tjmono_rx_arbiter_if.master    bus
);
  localparam int LW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_next_state;
  logic             r_run;
  logic [N_SRC-1:0] r_grant, w_next_grant;
  logic [LW-1:0]    r_last, w_next_last;
  logic [7:0]       r_tmo, w_next_tmo;
  logic [N_SRC-1:0] w_req, w_pick_oh, w_src_read;
  logic [LW-1:0]    w_pick;
  logic             w_pick_vld;
  logic [31:0]      w_pop_data;
  logic             w_pop, w_end, w_own_empty, w_tmo_hit;
  logic             r_out_write;
  logic [31:0]      r_out_data;
  logic             r_err;
  logic [7:0]       r_err_cnt;
  logic [31:0]      r_word_cnt;

  // Round robin: requesters above r_last win over the wrapped group at or below it
  always_comb begin
    w_req      = bus.SRC_ENABLE & ~bus.SRC_EMPTY;
    w_pick     = r_last;
    w_pick_vld = 1'b0;
    w_pick_oh  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_req[i] && (LW'(i) <= r_last)) begin
        w_pick     = LW'(i);
        w_pick_vld = 1'b1;
      end
    end
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_req[i] && (LW'(i) > r_last)) begin
        w_pick     = LW'(i);
        w_pick_vld = 1'b1;
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      w_pick_oh[i] = w_pick_vld && (LW'(i) == w_pick);
    end
  end

  always_comb begin
    w_pop_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant[i]) w_pop_data = bus.SRC_DATA[32*i +: 32];
    end
    w_src_read  = ((r_state == BUSY) && !bus.OUT_FULL) ? (r_grant & ~bus.SRC_EMPTY) : '0;
    w_pop       = |w_src_read;
    w_end       = w_pop && (w_pop_data[29:28] == 2'b11);
    w_own_empty = |(r_grant & bus.SRC_EMPTY);
    w_tmo_hit   = (r_state == BUSY) && w_own_empty && !bus.OUT_FULL
                  && (r_tmo == 8'(TIMEOUT - 1));
  end

  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    w_next_last  = r_last;
    w_next_tmo   = r_tmo;
    case (r_state)
      IDLE: begin
        if (r_run && w_pick_vld) begin
          w_next_state = BUSY;
          w_next_grant = w_pick_oh;
          w_next_last  = w_pick;
          w_next_tmo   = 8'd0;
        end
      end
      BUSY: begin
        if (w_end || w_tmo_hit) begin
          w_next_state = IDLE;
          w_next_grant = '0;
          w_next_tmo   = 8'd0;
        end else if (w_pop) begin
          w_next_tmo = 8'd0;
        end else if (w_own_empty && !bus.OUT_FULL) begin
          w_next_tmo = r_tmo + 8'd1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_grant = '0;
      end
    endcase
  end

  // r_run delays arbitration by one edge so reset release is seen synchronously
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
      r_grant <= '0;
      r_last  <= LW'(N_SRC - 1);
      r_tmo   <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
      r_grant <= w_next_grant;
      r_last  <= w_next_last;
      r_tmo   <= w_next_tmo;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_out_write <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_word_cnt  <= '0;
    end else begin
      r_out_write <= w_pop;
      if (w_pop) r_out_data <= w_pop_data;
      if (r_out_write) r_word_cnt <= r_word_cnt + 32'd1;
      if (bus.ERR_CLR) begin
        r_err     <= 1'b0;
        r_err_cnt <= 8'd0;
      end else if (w_tmo_hit) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.SRC_READ    = w_src_read;
  assign bus.OUT_WRITE   = r_out_write;
  assign bus.OUT_DATA    = r_out_data;
  assign bus.GRANT       = r_grant;
  assign bus.TIMEOUT_ERR = r_err;
  assign bus.TIMEOUT_CNT = r_err_cnt;
  assign bus.WORD_CNT    = r_word_cnt;
endmodule

// File: tb/tb_tjmono_rx_arbiter.sv
// tb/tb_tjmono_rx_arbiter.sv - directed self-checking bench for tjmono_rx_arbiter
module tb_tjmono_rx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tjmono_rx_arbiter_if #(.N_SRC(N)) bus();
  tjmono_rx_arbiter #(.N_SRC(N), .TIMEOUT(16)) dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] q[N][$];
  logic [N-1:0] rd_samp = '0;
  logic [N-1:0] prev_grant = '0;
  logic prev_rd = 1'b0;
  logic [31:0] out_log[$];
  int grant_log[$];
  int wr_cnt = 0, rd_cnt = 0, lat_err = 0, cyc = 0, wr_first = 0, wr_last = 0;

  function automatic logic [31:0] mkw(int src, int rec, int k);
    mkw = {2'(src), 2'(k), 4'h0, 8'(src), 8'(rec), 8'(k)};
  endfunction

  function automatic int oh2idx(logic [N-1:0] g);
    oh2idx = -1;
    if ($onehot(g)) for (int i = 0; i < N; i++) if (g[i]) oh2idx = i;
  endfunction

  // Source FIFO model: pops on the edge after SRC_READ is seen, refreshes outputs 2 ns later
  always begin
    for (int i = 0; i < N; i++) begin
      bus.SRC_EMPTY[i] = (q[i].size() == 0);
      bus.SRC_DATA[32*i +: 32] = (q[i].size() > 0) ? q[i][0] : 32'hDEAD_BEEF;
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) if (rd_samp[i] && q[i].size() > 0) void'(q[i].pop_front());
    #2;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rd_samp = '0;
      prev_rd = 1'b0;
      prev_grant = '0;
    end else begin
      if (bus.OUT_WRITE !== prev_rd) lat_err++;
      if (bus.OUT_WRITE === 1'b1) begin
        if (wr_cnt == 0) wr_first = cyc;
        wr_last = cyc;
        out_log.push_back(bus.OUT_DATA);
        wr_cnt++;
      end
      rd_samp = bus.SRC_READ;
      prev_rd = |bus.SRC_READ;
      if (|bus.SRC_READ) rd_cnt++;
      if (bus.GRANT != '0 && prev_grant == '0) grant_log.push_back(oh2idx(bus.GRANT));
      prev_grant = bus.GRANT;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rec(int src, int rec);
    for (int k = 0; k < 4; k++) q[src].push_back(mkw(src, rec, k));
  endtask

  task automatic clear_logs();
    out_log.delete();
    grant_log.delete();
    wr_cnt = 0; rd_cnt = 0; lat_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    bus.OUT_FULL = 1'b0;
    bus.SRC_ENABLE = '1;
    bus.ERR_CLR = 1'b0;
    tick(2);
    clear_logs();
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic wait_drained(string name, int bound);
    int n = 0;
    while (!(q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0
             && bus.GRANT == '0) && n < bound) begin
      tick(1);
      n++;
    end
    tick(3);
    total++; if (n >= bound) begin bad++; $display("FAIL %s_drain_bound got=%0d limit=%0d", name, n, bound); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.OUT_FULL = 1'b0; bus.SRC_ENABLE = '1; bus.ERR_CLR = 1'b0;
    tick(2);
    total++; if (bus.GRANT !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b exp=0000", bus.GRANT); end
    total++; if (bus.SRC_READ !== 4'b0) begin bad++; $display("FAIL reset_src_read got=%b exp=0000", bus.SRC_READ); end
    total++; if (bus.OUT_WRITE !== 1'b0) begin bad++; $display("FAIL reset_out_write got=%b exp=0", bus.OUT_WRITE); end
    total++; if (bus.OUT_DATA !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", bus.OUT_DATA); end
    total++; if (bus.TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.TIMEOUT_ERR); end
    total++; if (bus.TIMEOUT_CNT !== 8'h0) begin bad++; $display("FAIL reset_tcnt got=%0d exp=0", bus.TIMEOUT_CNT); end
    total++; if (bus.WORD_CNT !== 32'h0) begin bad++; $display("FAIL reset_wcnt got=%0d exp=0", bus.WORD_CNT); end
  endtask

  task automatic test_single_record();
    do_reset();
    push_rec(0, 0);
    tick(1);
    total++; if (bus.GRANT !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", bus.GRANT); end
    wait_drained("single", 50);
    total++; if (wr_cnt != 4) begin bad++; $display("FAIL single_writes got=%0d exp=4", wr_cnt); end
    total++; if (wr_last - wr_first != 3) begin bad++; $display("FAIL single_contiguous got=%0d exp=3", wr_last - wr_first); end
    total++; if (lat_err != 0) begin bad++; $display("FAIL single_latency got=%0d exp=0", lat_err); end
    total++; if (bus.WORD_CNT !== 32'd4) begin bad++; $display("FAIL single_wcnt got=%0d exp=4", bus.WORD_CNT); end
    total++; if (bus.GRANT !== 4'b0) begin bad++; $display("FAIL single_idle_grant got=%b exp=0000", bus.GRANT); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_log.size() <= k || out_log[k] !== mkw(0, 0, k)) begin
        bad++; $display("FAIL single_word%0d got=%h exp=%h", k, (out_log.size() > k) ? out_log[k] : 32'hX, mkw(0, 0, k));
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) push_rec(s, r);
    wait_drained("rr", 300);
    total++; if (grant_log.size() != 8) begin bad++; $display("FAIL rr_grant_count got=%0d exp=8", grant_log.size()); end
    for (int j = 0; j < 8 && j < grant_log.size(); j++) begin
      total++; if (grant_log[j] != j % 4) begin bad++; $display("FAIL rr_order%0d got=%0d exp=%0d", j, grant_log[j], j % 4); end
    end
    total++; if (out_log.size() != 32) begin bad++; $display("FAIL rr_words got=%0d exp=32", out_log.size()); end
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (out_log.size() == 32) begin
          total++;
          if (out_log[4*j+k] !== mkw(j % 4, j / 4, k)) begin
            bad++; $display("FAIL rr_word%0d got=%h exp=%h", 4*j+k, out_log[4*j+k], mkw(j % 4, j / 4, k));
          end
        end
      end
    end
    total++; if (bus.WORD_CNT !== 32'd32) begin bad++; $display("FAIL rr_wcnt got=%0d exp=32", bus.WORD_CNT); end
    total++; if (lat_err != 0) begin bad++; $display("FAIL rr_latency got=%0d exp=0", lat_err); end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    q[1].push_back(mkw(1, 0, 0));
    q[1].push_back(mkw(1, 0, 1));
    tick(1);
    total++; if (bus.GRANT !== 4'b0010) begin bad++; $display("FAIL tmo_grant got=%b exp=0010", bus.GRANT); end
    while (bus.GRANT != '0 && n < 100) begin
      tick(1);
      n++;
    end
    total++; if (n != 18) begin bad++; $display("FAIL tmo_hold_cycles got=%0d exp=18", n); end
    total++; if (wr_cnt != 2) begin bad++; $display("FAIL tmo_writes got=%0d exp=2", wr_cnt); end
    total++; if (bus.TIMEOUT_ERR !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", bus.TIMEOUT_ERR); end
    total++; if (bus.TIMEOUT_CNT !== 8'd1) begin bad++; $display("FAIL tmo_cnt got=%0d exp=1", bus.TIMEOUT_CNT); end
    tick(3);
    total++; if (bus.OUT_WRITE !== 1'b0 || wr_cnt != 2) begin bad++; $display("FAIL tmo_no_filler got=%0d exp=2", wr_cnt); end
    bus.ERR_CLR = 1'b1;
    tick(1);
    bus.ERR_CLR = 1'b0;
    tick(1);
    total++; if (bus.TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL tmo_clr_err got=%b exp=0", bus.TIMEOUT_ERR); end
    total++; if (bus.TIMEOUT_CNT !== 8'd0) begin bad++; $display("FAIL tmo_clr_cnt got=%0d exp=0", bus.TIMEOUT_CNT); end
  endtask

  task automatic test_full_stall();
    int n = 0;
    int rd0;
    do_reset();
    q[0].push_back(mkw(0, 0, 0));
    q[0].push_back(mkw(0, 0, 1));
    while (wr_cnt < 2 && n < 20) begin
      tick(1);
      n++;
    end
    total++; if (n >= 20) begin bad++; $display("FAIL stall_first_words got=%0d exp=2", wr_cnt); end
    bus.OUT_FULL = 1'b1;
    tick(20);
    total++; if (bus.GRANT !== 4'b0001) begin bad++; $display("FAIL stall_grant_empty got=%b exp=0001", bus.GRANT); end
    total++; if (bus.TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL stall_no_timeout got=%b exp=0", bus.TIMEOUT_ERR); end
    q[0].push_back(mkw(0, 0, 2));
    q[0].push_back(mkw(0, 0, 3));
    rd0 = rd_cnt;
    tick(10);
    total++; if (rd_cnt != rd0) begin bad++; $display("FAIL stall_no_read got=%0d exp=%0d", rd_cnt, rd0); end
    total++; if (bus.GRANT !== 4'b0001) begin bad++; $display("FAIL stall_grant_held got=%b exp=0001", bus.GRANT); end
    bus.OUT_FULL = 1'b0;
    wait_drained("stall", 50);
    total++; if (out_log.size() != 4) begin bad++; $display("FAIL stall_words got=%0d exp=4", out_log.size()); end
    for (int k = 0; k < 4 && k < out_log.size(); k++) begin
      total++; if (out_log[k] !== mkw(0, 0, k)) begin bad++; $display("FAIL stall_word%0d got=%h exp=%h", k, out_log[k], mkw(0, 0, k)); end
    end
    total++; if (bus.WORD_CNT !== 32'd4) begin bad++; $display("FAIL stall_wcnt got=%0d exp=4", bus.WORD_CNT); end
    total++; if (lat_err != 0) begin bad++; $display("FAIL stall_latency got=%0d exp=0", lat_err); end
  endtask

  task automatic test_enable_mask();
    int n = 0;
    do_reset();
    bus.SRC_ENABLE = 4'b1011;
    push_rec(2, 0);
    push_rec(0, 0);
    tick(1);
    total++; if (bus.GRANT !== 4'b0001) begin bad++; $display("FAIL mask_grant0 got=%b exp=0001", bus.GRANT); end
    bus.SRC_ENABLE = 4'b1010;
    while (!(q[0].size() == 0 && bus.GRANT == '0) && n < 30) begin
      tick(1);
      n++;
    end
    tick(10);
    total++; if (out_log.size() != 4) begin bad++; $display("FAIL mask_src0_words got=%0d exp=4", out_log.size()); end
    for (int k = 0; k < 4 && k < out_log.size(); k++) begin
      total++; if (out_log[k] !== mkw(0, 0, k)) begin bad++; $display("FAIL mask_word%0d got=%h exp=%h", k, out_log[k], mkw(0, 0, k)); end
    end
    total++; if (grant_log.size() != 1) begin bad++; $display("FAIL mask_grant_count got=%0d exp=1", grant_log.size()); end
    total++; if (q[2].size() != 4) begin bad++; $display("FAIL mask_src2_untouched got=%0d exp=4", q[2].size()); end
    bus.SRC_ENABLE = 4'b1111;
    tick(1);
    total++; if (bus.GRANT !== 4'b0100) begin bad++; $display("FAIL mask_src2_after_enable got=%b exp=0100", bus.GRANT); end
    wait_drained("mask", 50);
  endtask

  task automatic test_reset_mid_record();
    int n = 0;
    do_reset();
    push_rec(0, 1);
    push_rec(1, 1);
    while (wr_cnt < 2 && n < 20) begin
      tick(1);
      n++;
    end
    rst_n = 1'b0;
    #1;
    total++; if (bus.GRANT !== 4'b0) begin bad++; $display("FAIL midrst_grant got=%b exp=0000", bus.GRANT); end
    total++; if (bus.SRC_READ !== 4'b0) begin bad++; $display("FAIL midrst_read got=%b exp=0000", bus.SRC_READ); end
    total++; if (bus.OUT_WRITE !== 1'b0) begin bad++; $display("FAIL midrst_write got=%b exp=0", bus.OUT_WRITE); end
    total++; if (bus.OUT_DATA !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h exp=0", bus.OUT_DATA); end
    total++; if (bus.WORD_CNT !== 32'h0) begin bad++; $display("FAIL midrst_wcnt got=%0d exp=0", bus.WORD_CNT); end
    total++; if (bus.TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", bus.TIMEOUT_ERR); end
    total++; if (q[0].size() != 1) begin bad++; $display("FAIL midrst_tail_kept got=%0d exp=1", q[0].size()); end
    tick(2);
    clear_logs();
    rst_n = 1'b1;
    tick(1);
    total++; if (bus.GRANT !== 4'b0) begin bad++; $display("FAIL midrst_edge1_grant got=%b exp=0000", bus.GRANT); end
    tick(1);
    total++; if (bus.GRANT !== 4'b0001) begin bad++; $display("FAIL midrst_edge2_grant got=%b exp=0001", bus.GRANT); end
    wait_drained("midrst", 50);
    total++; if (bus.TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL midrst_err_after got=%b exp=0", bus.TIMEOUT_ERR); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_record();
    test_round_robin();
    test_timeout();
    test_full_stall();
    test_enable_mask();
    test_reset_mid_record();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
